// File: rtl/bt656_pkg.sv
// Shared constants and types for the BT.656 -> RGB565 write path.
package bt656_pkg;

    localparam int K_RV       = 359;
    localparam int K_GU       = 88;
    localparam int K_GV       = 183;
    localparam int K_BU       = 454;
    localparam int CHROMA_OFS = 128;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic logic [7:0] clamp8(input logic signed [17:0] val);
        if (val < 0)
            return 8'd0;
        else if (val > 18'sd255)
            return 8'hFF;
        else
            return val[7:0];
    endfunction

endpackage

// File: rtl/ycbcr2rgb565.sv
// 3-stage YCbCr -> RGB565 pipeline with a travelling valid bit.
// BT656_WR_COLOR_EN selects full colour conversion; otherwise grayscale (R=G=B=Y).
module ycbcr2rgb565
    import bt656_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_vld,
    input  logic [7:0] y,
    input  logic [7:0] cb,
    input  logic [7:0] cr,
    output logic       out_vld,
    output rgb565_t    out_pix
);

    logic [3:1] vld_pipe;
    logic [7:0] r8, g8, b8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[2:1], in_vld};
    end

`ifdef BT656_WR_COLOR_EN
    int                 d_cb, d_cr;
    logic [7:0]         s1_y;
    logic signed [17:0] s1_prv, s1_pgu, s1_pgv, s1_pbu;
    logic signed [17:0] y18;
    logic signed [17:0] s2_r, s2_g, s2_b;

    always_comb begin
        d_cb = int'(cb) - CHROMA_OFS;
        d_cr = int'(cr) - CHROMA_OFS;
    end

    assign y18 = $signed({10'd0, s1_y});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_y   <= '0;
            s1_prv <= '0;
            s1_pgu <= '0;
            s1_pgv <= '0;
            s1_pbu <= '0;
            s2_r   <= '0;
            s2_g   <= '0;
            s2_b   <= '0;
        end else begin
            s1_y   <= y;
            s1_prv <= 18'(K_RV * d_cr);
            s1_pgu <= 18'(K_GU * d_cb);
            s1_pgv <= 18'(K_GV * d_cr);
            s1_pbu <= 18'(K_BU * d_cb);
            s2_r   <= y18 + (s1_prv >>> 8);
            s2_g   <= y18 - ((s1_pgu + s1_pgv) >>> 8);
            s2_b   <= y18 + (s1_pbu >>> 8);
        end
    end

    always_comb begin
        r8 = clamp8(s2_r);
        g8 = clamp8(s2_g);
        b8 = clamp8(s2_b);
    end
`else
    // Grayscale: chroma is ignored, two plain delay stages keep the latency at 3.
    logic [7:0] s1_y, s2_y;
    logic       unused_chroma;

    assign unused_chroma = ^{cb, cr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_y <= '0;
            s2_y <= '0;
        end else begin
            s1_y <= y;
            s2_y <= s1_y;
        end
    end

    always_comb begin
        r8 = s2_y;
        g8 = s2_y;
        b8 = s2_y;
    end
`endif

    logic unused_lsb;
    assign unused_lsb = ^{r8[2:0], g8[1:0], b8[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_pix <= '0;
        else        out_pix <= '{r: r8[7:3], g: g8[7:2], b: b8[7:3]};
    end

    assign out_vld = vld_pipe[3];

endmodule

// File: rtl/bt656_rgb_writer.sv
// BT.656 stream -> cropped RGB565 FIFO writes, frame-start pulse and sticky overflow.
// Colour conversion is enabled by defining BT656_WR_COLOR_EN (grayscale otherwise).
module bt656_rgb_writer
    import bt656_pkg::*;
#(
    parameter int H_START = 40,
    parameter int H_ACT   = 640,
    parameter int V_START = 20,
    parameter int V_ACT   = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic [7:0]  y,
    input  logic [7:0]  cb,
    input  logic [7:0]  cr,
    input  logic        v,
    input  logic        h,
    input  logic [8:0]  line,
    input  logic        wr_full,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic        frame_start,
    output logic        ovf
);

    localparam logic [10:0] H_LO = 11'(H_START);
    localparam logic [10:0] H_HI = 11'(H_START + H_ACT);
    localparam logic [8:0]  V_LO = 9'(V_START);
    localparam logic [8:0]  V_HI = 9'(V_START + V_ACT);

    logic [10:0] pix_cnt;
    logic        armed;
    logic        v_q;
    logic        in_win;
    logic        pipe_vld;
    rgb565_t     pipe_pix;

    // armed blocks capture after reset until a blanking interval realigns pix_cnt.
    assign in_win = pix_en && armed && !h && !v
                 && (line >= V_LO) && (line < V_HI)
                 && (pix_cnt >= H_LO) && (pix_cnt < H_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            armed   <= 1'b0;
        end else if (h || v) begin
            pix_cnt <= '0;
            armed   <= 1'b1;
        end else if (pix_en && pix_cnt != 11'h7FF) begin
            pix_cnt <= pix_cnt + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            v_q         <= v;
            frame_start <= v_q && !v;
        end
    end

    // A drop in the frame_start cycle must survive the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  ovf <= 1'b0;
        else if (pipe_vld && wr_full) ovf <= 1'b1;
        else if (frame_start)        ovf <= 1'b0;
    end

    ycbcr2rgb565 u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_win),
        .y       (y),
        .cb      (cb),
        .cr      (cr),
        .out_vld (pipe_vld),
        .out_pix (pipe_pix)
    );

    assign wr_en   = pipe_vld && !wr_full;
    assign wr_data = pipe_pix;

endmodule
